// File: rtl/apb_slv_pkg.sv
// Shared types and default parameter values for the APB register bank.
//   apb_state_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   *_DEF       : default values for ADDR_W, DATA_W, DEPTH, WAIT_CYCLES
//   WCNT_W      : width of the wait-state counter (WAIT_CYCLES is 0..15)
package apb_slv_pkg;

    localparam int unsigned ADDR_W_DEF      = 8;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned DEPTH_DEF       = 16;
    localparam int unsigned WAIT_CYCLES_DEF = 1;
    localparam int unsigned WCNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_slv_regbank.sv
// Register array behind the APB completer.
//   PCLK, PRESETn : clock, async active-low reset (clears every register)
//   we            : commit write this cycle
//   widx, wdata   : word index and data of the write
//   wstrb         : byte enables of the write
//   ridx          : word index for the read mux
//   rdata_c       : combinational read data at ridx
module apb_slv_regbank #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write; reset clears the whole array
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[ridx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer fronting a bank of DEPTH word registers.
//   PCLK, PRESETn        : clock, async active-low reset
//   PSELx, PENABLE       : select / access-phase strobes
//   PWRITE, PADDR, PWDATA: transfer request, sampled when leaving IDLE
//   PSTRB                : byte strobes (only with APB_SLV_PSTRB_EN defined)
//   PRDATA, PREADY,
//   PSLVERR              : registered completion outputs
// Optional feature macro: APB_SLV_PSTRB_EN enables the PSTRB port and
// byte-masked writes; without it every write updates all bytes.
module apb_slave_regbank
    import apb_slv_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSELx,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned MAX_ADDR = DEPTH * 4;

    apb_state_e          state_q,  state_d;
    logic [WCNT_W-1:0]   wcnt_q,   wcnt_d;
    logic                wr_q,     wr_d;
    logic                err_q,    err_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [STRB_W-1:0]   strb_q,   strb_d;
    logic                ready_q,  ready_d;
    logic                slverr_q, slverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;

    logic                addr_err_c;
    logic                we_c;
    logic [STRB_W-1:0]   strb_in_c;
    logic [DATA_W-1:0]   rdata_c;

    // Misaligned or beyond the last register
    assign addr_err_c = (PADDR[1:0] != 2'b00) || (32'(PADDR) >= MAX_ADDR);

`ifdef APB_SLV_PSTRB_EN
    assign strb_in_c = PSTRB;
`else
    assign strb_in_c = '1;
`endif

    // Request fields are latched on the IDLE->SETUP edge, so bus changes
    // later in the transfer have no effect.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;

        unique case (state_q)
            IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_d = SETUP;
                    wcnt_d  = WCNT_W'(WAIT_CYCLES);
                    wr_d    = PWRITE;
                    err_d   = addr_err_c;
                    idx_d   = PADDR[IDX_W+1:2];
                    wdata_d = PWDATA;
                    strb_d  = strb_in_c;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!PSELx || ready_q) begin
                    state_d = IDLE;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they come from flops
        ready_d  = (state_d == ACCESS) && (wcnt_d == '0);
        slverr_d = ready_d && err_q;
        prdata_d = (ready_d && !err_q && !wr_q) ? rdata_c : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            prdata_q <= prdata_d;
        end
    end

    // Commit only on a completing, still-selected, error-free write
    assign we_c = PSELx && PENABLE && wr_q && ready_q && !err_q;

    apb_slv_regbank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regbank (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (we_c),
        .widx    (idx_q),
        .wdata   (wdata_q),
        .wstrb   (strb_q),
        .ridx    (idx_q),
        .rdata_c (rdata_c)
    );

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: one instance with WAIT_CYCLES=1
// (index 1) and one with WAIT_CYCLES=0 (index 0) on a shared clock/reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_apb_slave_regbank;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int n_cmp = 0;
    int n_err = 0;

    apb_slave_regbank #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PSELx   (psel[0]),
        .PENABLE (penable[0]),
        .PWRITE  (pwrite[0]),
        .PADDR   (paddr[0]),
        .PWDATA  (pwdata[0]),
`ifdef APB_SLV_PSTRB_EN
        .PSTRB   (pstrb[0]),
`endif
        .PRDATA  (prdata[0]),
        .PREADY  (pready[0]),
        .PSLVERR (pslverr[0])
    );

    apb_slave_regbank #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(1)) dut1 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PSELx   (psel[1]),
        .PENABLE (penable[1]),
        .PWRITE  (pwrite[1]),
        .PADDR   (paddr[1]),
        .PWDATA  (pwdata[1]),
`ifdef APB_SLV_PSTRB_EN
        .PSTRB   (pstrb[1]),
`endif
        .PRDATA  (prdata[1]),
        .PREADY  (pready[1]),
        .PSLVERR (pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Setup cycle, then the first access-phase cycle
    task automatic setup_phase(input bit d, input bit wr, input logic [7:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input string tag);
        @(negedge clk);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        pstrb[d]   = strb;
        check({tag, "_idle_rdy"}, 32'(pready[d]), 32'd0);
        check({tag, "_idle_rd"}, prdata[d], 32'd0);
        @(posedge clk);
        @(negedge clk);
        penable[d] = 1'b1;
        check({tag, "_setup_rdy"}, 32'(pready[d]), 32'd0);
    endtask

    // n = rising edges since the setup cycle when PREADY is first seen (bounded)
    task automatic wait_ready(input bit d, output int n);
        n = 1;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!pready[d] && n < 20);
    endtask

    task automatic xfer(input bit d, input bit wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input bit scr,
                        input int lat, input bit err, input logic [31:0] rd, input string tag);
        int n;
        setup_phase(d, wr, addr, data, strb, tag);
        if (scr) begin
            paddr[d]  = addr ^ 8'h0C;
            pwdata[d] = ~data;
            pwrite[d] = ~wr;
        end
        wait_ready(d, n);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_err"}, 32'(pslverr[d]), 32'(err));
        check({tag, "_rdata"}, prdata[d], wr ? 32'd0 : rd);
        @(posedge clk);
    endtask

    task automatic bus_idle(input bit d);
        @(negedge clk);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = 8'h00; pwdata[i] = 32'h0; pstrb[i] = 4'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_rdy", 32'(pready[i]), 32'd0);
            check("rst_err", 32'(pslverr[i]), 32'd0);
            check("rst_rd", prdata[i], 32'd0);
        end
        rst_n = 1'b1;

        // Basic write/read with one wait state
        xfer(1'b1, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 3, 1'b0, 32'h0, "wr04"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'hDEADBEEF, "rd04"); bus_idle(1'b1);

        // Address errors: out of range (aliases reg 0), misaligned read/write
        xfer(1'b1, 1'b1, 8'h40, 32'h12345678, 4'hF, 1'b0, 3, 1'b1, 32'h0, "wr40"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h06, 32'h0, 4'hF, 1'b0, 3, 1'b1, 32'h0, "rd06"); bus_idle(1'b1);
        xfer(1'b1, 1'b1, 8'h05, 32'hCAFEF00D, 4'hF, 1'b0, 3, 1'b1, 32'h0, "wr05"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h0, "rd00_noalias"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'hDEADBEEF, "rd04_kept"); bus_idle(1'b1);

        // Request fields changed after setup must be ignored
        xfer(1'b1, 1'b1, 8'h14, 32'hA5A50F0F, 4'hF, 1'b1, 3, 1'b0, 32'h0, "wr14_scr"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h14, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'hA5A50F0F, "rd14"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h18, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h0, "rd18"); bus_idle(1'b1);

        // PSELx+PENABLE without a setup phase is ignored
        @(negedge clk);
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1;
        paddr[1] = 8'h1C; pwdata[1] = 32'h77777777;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("nosetup_rdy", 32'(pready[1]), 32'd0);
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        xfer(1'b1, 1'b0, 8'h1C, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h0, "rd1c"); bus_idle(1'b1);

        // Abort: PSELx dropped in the ready cycle of a write
        setup_phase(1'b1, 1'b1, 8'h0C, 32'h0BADC0DE, 4'hF, "abort");
        wait_ready(1'b1, n);
        check("abort_lat", 32'(n), 32'd3);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_idle_rdy", 32'(pready[1]), 32'd0);
        xfer(1'b1, 1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h0, "rd0c"); bus_idle(1'b1);

`ifdef APB_SLV_PSTRB_EN
        xfer(1'b1, 1'b1, 8'h08, 32'h11223344, 4'b0101, 1'b0, 3, 1'b0, 32'h0, "wr08_strb"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h00220044, "rd08_strb"); bus_idle(1'b1);
        xfer(1'b1, 1'b1, 8'h08, 32'hFFFFFFFF, 4'b0000, 1'b0, 3, 1'b0, 32'h0, "wr08_zero"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h00220044, "rd08_zero"); bus_idle(1'b1);
`else
        xfer(1'b1, 1'b1, 8'h08, 32'h11223344, 4'b0101, 1'b0, 3, 1'b0, 32'h0, "wr08_full"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h11223344, "rd08_full"); bus_idle(1'b1);
`endif

        // Back-to-back on the zero-wait instance
        xfer(1'b0, 1'b1, 8'h00, 32'h01010101, 4'hF, 1'b0, 2, 1'b0, 32'h0, "b2b_wr00");
        xfer(1'b0, 1'b1, 8'h04, 32'h02020202, 4'hF, 1'b0, 2, 1'b0, 32'h0, "b2b_wr04");
        xfer(1'b0, 1'b1, 8'h08, 32'h03030303, 4'hF, 1'b0, 2, 1'b0, 32'h0, "b2b_wr08");
        xfer(1'b0, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 2, 1'b0, 32'h01010101, "b2b_rd00");
        xfer(1'b0, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 2, 1'b0, 32'h02020202, "b2b_rd04");
        xfer(1'b0, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0, 2, 1'b0, 32'h03030303, "b2b_rd08");
        bus_idle(1'b0);

        // Reset while a read is presenting data clears outputs at once
        setup_phase(1'b1, 1'b0, 8'h04, 32'h0, 4'hF, "rstrd");
        wait_ready(1'b1, n);
        check("rstrd_data", prdata[1], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("rstrd_async_rd", prdata[1], 32'd0);
        check("rstrd_async_rdy", 32'(pready[1]), 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the wait state of a write
        setup_phase(1'b1, 1'b1, 8'h10, 32'h55AA55AA, 4'hF, "rstwr");
        @(posedge clk);
        @(negedge clk);
        check("rstwr_wait_rdy", 32'(pready[1]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstwr_async_rdy", 32'(pready[1]), 32'd0);
        check("rstwr_async_err", 32'(pslverr[1]), 32'd0);
        check("rstwr_async_rd", prdata[1], 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b1, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h0, "rd10_after_rst"); bus_idle(1'b1);
        xfer(1'b1, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 3, 1'b0, 32'h0, "rd04_after_rst"); bus_idle(1'b1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
